// File: rtl/lfsr_pkg.sv
// -----------------------------------------------------------------------------
// lfsr_pkg
// Shared definitions for the LFSR / PRBS generator:
//   - lfsr_mode_e   : feedback topology (Fibonacci or Galois)
//   - lfsr_gal_taps : maximal-length Galois tap mask for widths 3..32
//   - lfsr_fib_taps : the equivalent Fibonacci tap mask for widths 3..32
//   - lfsr_taps_ok  : checks that a tap mask is usable with a topology
// -----------------------------------------------------------------------------
package lfsr_pkg;

    typedef enum logic [0:0] {
        LFSR_FIB = 1'b0,
        LFSR_GAL = 1'b1
    } lfsr_mode_e;

    localparam int unsigned LFSR_MIN_W = 3;
    localparam int unsigned LFSR_MAX_W = 32;

    // Maximal-length masks for the right-shifting Galois form,
    // next = (s >> 1) ^ (s[0] ? mask : 0). Zero for unsupported widths.
    function automatic logic [31:0] lfsr_gal_taps(input int unsigned w);
        logic [31:0] m;
        case (w)
            3:       m = 32'h0000_0006;
            4:       m = 32'h0000_000C;
            5:       m = 32'h0000_0014;
            6:       m = 32'h0000_0030;
            7:       m = 32'h0000_0060;
            8:       m = 32'h0000_00B8;
            9:       m = 32'h0000_0110;
            10:      m = 32'h0000_0240;
            11:      m = 32'h0000_0500;
            12:      m = 32'h0000_0829;
            13:      m = 32'h0000_100D;
            14:      m = 32'h0000_2015;
            15:      m = 32'h0000_6000;
            16:      m = 32'h0000_B400;
            17:      m = 32'h0001_2000;
            18:      m = 32'h0002_0400;
            19:      m = 32'h0004_0023;
            20:      m = 32'h0009_0000;
            21:      m = 32'h0014_0000;
            22:      m = 32'h0030_0000;
            23:      m = 32'h0042_0000;
            24:      m = 32'h00E1_0000;
            25:      m = 32'h0120_0000;
            26:      m = 32'h0200_0023;
            27:      m = 32'h0400_0013;
            28:      m = 32'h0900_0000;
            29:      m = 32'h1400_0000;
            30:      m = 32'h2000_0029;
            31:      m = 32'h4800_0000;
            32:      m = 32'h8020_0003;
            default: m = 32'h0000_0000;
        endcase
        return m;
    endfunction

    // The Fibonacci form (fb = ^(s & mask), shifted in at the MSB) that
    // produces the same sequence family is the Galois mask bit-reversed
    // within the register width, e.g. 16'hB400 <-> 16'h002D.
    function automatic logic [31:0] lfsr_fib_taps(input int unsigned w);
        logic [31:0] g;
        logic [31:0] f;
        g = lfsr_gal_taps(w);
        f = 32'h0000_0000;
        for (int unsigned i = 0; i < LFSR_MAX_W; i++) begin
            if (i < w) begin
                f[5'(w - 32'd1 - i)] = g[5'(i)];
            end else begin
                f = f;
            end
        end
        return f;
    endfunction

    // Fibonacci needs the LSB tap (the bit leaving the register must feed
    // back); Galois needs the MSB tap (the feedback must re-enter the top).
    // Without them the map is not a permutation and the state can collapse.
    function automatic bit lfsr_taps_ok(input lfsr_mode_e mode,
                                        input logic       tap_lsb,
                                        input logic       tap_msb);
        bit ok;
        case (mode)
            LFSR_FIB: ok = (tap_lsb == 1'b1);
            LFSR_GAL: ok = (tap_msb == 1'b1);
            default:  ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage : lfsr_pkg

// File: rtl/lfsr_next_state.sv
// -----------------------------------------------------------------------------
// lfsr_next_state
// Purely combinational single-step LFSR map.
// Ports:
//   i_state  WIDTH  current state s
//   o_next   WIDTH  state after one step
//   o_bit    1      bit shifted out by that step (s[0] in both topologies)
// -----------------------------------------------------------------------------
module lfsr_next_state
    import lfsr_pkg::*;
#(
    parameter int unsigned          WIDTH = 16,
    parameter lfsr_mode_e           MODE  = LFSR_GAL,
    parameter logic [WIDTH-1:0]     TAPS  = 16'hB400
) (
    input  logic [WIDTH-1:0] i_state,
    output logic [WIDTH-1:0] o_next,
    output logic             o_bit
);

    assign o_bit = i_state[0];

    if (MODE == LFSR_FIB) begin : g_fib
        logic w_fb;
        // Fibonacci step: parity of tapped bits enters at the MSB.
        always_comb begin
            w_fb   = ^(i_state & TAPS);
            o_next = {w_fb, i_state[WIDTH-1:1]};
        end
    end else begin : g_gal
        // Galois step: shift right, XOR the mask in when a 1 falls out.
        always_comb begin
            o_next = (i_state >> 1) ^ ({WIDTH{i_state[0]}} & TAPS);
        end
    end

endmodule : lfsr_next_state

// File: rtl/lfsr_prbs_gen.sv
// -----------------------------------------------------------------------------
// lfsr_prbs_gen
// Parametrised LFSR / PRBS generator with seed load, step enable, zero-seed
// lockup protection, period-wrap strobe and step counter. All outputs are
// registered.
// Ports:
//   clk         in   1      rising-edge clock
//   rst_n       in   1      asynchronous active-low reset
//   en          in   1      advance one step this cycle
//   load        in   1      load seed this cycle (priority over en)
//   seed        in   WIDTH  seed value, sampled when load=1
//   state       out  WIDTH  current LFSR state
//   bit_out     out  1      bit shifted out by the most recent step
//   wrap        out  1      pulse: last step returned state to the active seed
//   lockup_err  out  1      sticky: a zero seed was loaded / zero state seen
//   step_cnt    out  CNT_W  steps since last reset, load or wrap
// -----------------------------------------------------------------------------
module lfsr_prbs_gen
    import lfsr_pkg::*;
#(
    parameter int unsigned          WIDTH      = 16,
    parameter lfsr_mode_e           MODE       = LFSR_GAL,
    parameter logic [WIDTH-1:0]     TAPS       = 16'hB400,
    parameter logic [WIDTH-1:0]     RESET_SEED = 16'h0001,
    parameter int                   CNT_W      = WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] seed,
    output logic [WIDTH-1:0] state,
    output logic             bit_out,
    output logic             wrap,
    output logic             lockup_err,
    output logic [CNT_W-1:0] step_cnt
);

    localparam logic [WIDTH-1:0] ZERO_STATE = {WIDTH{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1'b1);

    // Configuration errors that would make the generator lock up or be
    // meaningless are rejected at elaboration.
    if (WIDTH < LFSR_MIN_W) begin : g_bad_width
        $fatal(1, "lfsr_prbs_gen: WIDTH must be >= 3");
    end
    if (RESET_SEED == ZERO_STATE) begin : g_bad_seed
        $fatal(1, "lfsr_prbs_gen: RESET_SEED must be nonzero");
    end
    if (!lfsr_taps_ok(MODE, TAPS[0], TAPS[WIDTH-1])) begin : g_bad_taps
        $fatal(1, "lfsr_prbs_gen: TAPS missing the end tap required by MODE");
    end
    if (CNT_W < 1) begin : g_bad_cnt
        $fatal(1, "lfsr_prbs_gen: CNT_W must be >= 1");
    end

    logic [WIDTH-1:0] r_state;
    logic [WIDTH-1:0] r_seed;
    logic             r_bit;
    logic             r_wrap;
    logic             r_lock;
    logic [CNT_W-1:0] r_cnt;

    logic [WIDTH-1:0] w_next;
    logic             w_shift_bit;

    lfsr_next_state #(
        .WIDTH (WIDTH),
        .MODE  (MODE),
        .TAPS  (TAPS)
    ) u_next (
        .i_state (r_state),
        .o_next  (w_next),
        .o_bit   (w_shift_bit)
    );

    // State, seed, strobe, counter and lockup registers with load > recovery > step priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= RESET_SEED;
            r_seed  <= RESET_SEED;
            r_bit   <= 1'b0;
            r_wrap  <= 1'b0;
            r_lock  <= 1'b0;
            r_cnt   <= CNT_ZERO;
        end else if (load) begin
            // A zero seed would lock the register at zero forever; substitute
            // the reset seed and flag it. bit_out holds on any load.
            if (seed != ZERO_STATE) begin
                r_state <= seed;
                r_seed  <= seed;
                r_lock  <= 1'b0;
            end else begin
                r_state <= RESET_SEED;
                r_seed  <= RESET_SEED;
                r_lock  <= 1'b1;
            end
            r_cnt  <= CNT_ZERO;
            r_wrap <= 1'b0;
        end else if (r_state == ZERO_STATE) begin
            // Unreachable with legal taps; recovers from an upset state bit.
            r_state <= RESET_SEED;
            r_lock  <= 1'b1;
            r_wrap  <= 1'b0;
        end else if (en) begin
            r_state <= w_next;
            r_bit   <= w_shift_bit;
            if (w_next == r_seed) begin
                r_wrap <= 1'b1;
                r_cnt  <= CNT_ZERO;
            end else begin
                r_wrap <= 1'b0;
                r_cnt  <= r_cnt + CNT_ONE;
            end
        end else begin
            r_wrap <= 1'b0;
        end
    end

    assign state      = r_state;
    assign bit_out    = r_bit;
    assign wrap       = r_wrap;
    assign lockup_err = r_lock;
    assign step_cnt   = r_cnt;

endmodule : lfsr_prbs_gen

// File: tb/tb_lfsr_prbs_gen.sv
// -----------------------------------------------------------------------------
// tb_lfsr_prbs_gen
// Directed self-checking bench. Three generator instances share clk/rst_n:
//   u_dut  : default 16-bit Galois (0xB400)
//   u_fib3 : 3-bit Fibonacci, taps 3'b011
//   u_gal3 : 3-bit Galois,    taps 3'b110
// -----------------------------------------------------------------------------
module tb_lfsr_prbs_gen;
    import lfsr_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        load;
    logic [15:0] seed;
    logic [15:0] state;
    logic        bit_out;
    logic        wrap;
    logic        lockup_err;
    logic [15:0] step_cnt;

    logic        en3;
    logic        load3;
    logic [2:0]  seed3;
    logic [2:0]  f_state;
    logic        f_bit;
    logic        f_wrap;
    logic        f_lock;
    logic [2:0]  f_cnt;
    logic [2:0]  g_state;
    logic        g_bit;
    logic        g_wrap;
    logic        g_lock;
    logic [2:0]  g_cnt;

    int errors;
    int checks;

    lfsr_prbs_gen u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .load       (load),
        .seed       (seed),
        .state      (state),
        .bit_out    (bit_out),
        .wrap       (wrap),
        .lockup_err (lockup_err),
        .step_cnt   (step_cnt)
    );

    lfsr_prbs_gen #(
        .WIDTH(3), .MODE(LFSR_FIB), .TAPS(3'b011), .RESET_SEED(3'b001), .CNT_W(3)
    ) u_fib3 (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en3),
        .load       (load3),
        .seed       (seed3),
        .state      (f_state),
        .bit_out    (f_bit),
        .wrap       (f_wrap),
        .lockup_err (f_lock),
        .step_cnt   (f_cnt)
    );

    lfsr_prbs_gen #(
        .WIDTH(3), .MODE(LFSR_GAL), .TAPS(3'b110), .RESET_SEED(3'b001), .CNT_W(3)
    ) u_gal3 (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en3),
        .load       (load3),
        .seed       (seed3),
        .state      (g_state),
        .bit_out    (g_bit),
        .wrap       (g_wrap),
        .lockup_err (g_lock),
        .step_cnt   (g_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        checks++;
        if (state !== 16'h0001) begin
            errors++; $display("FAIL reset_state: got %h expected 0001", state);
        end
        checks++;
        if ({bit_out, wrap, lockup_err} !== 3'b000) begin
            errors++; $display("FAIL reset_flags: got bit/wrap/lock=%b expected 000", {bit_out, wrap, lockup_err});
        end
        checks++;
        if (step_cnt !== 16'h0000) begin
            errors++; $display("FAIL reset_cnt: got %0d expected 0", step_cnt);
        end
        checks++;
        if ({f_state, g_state} !== 6'b001_001) begin
            errors++; $display("FAIL reset_small: got fib=%b gal=%b expected 001 001", f_state, g_state);
        end
    endtask

    task automatic test_small_widths();
        logic [2:0] fib_exp [7];
        logic [2:0] gal_exp [7];
        logic       fib_bit [7];
        logic       gal_bit [7];
        fib_exp = '{3'b100, 3'b010, 3'b101, 3'b110, 3'b111, 3'b011, 3'b001};
        gal_exp = '{3'b110, 3'b011, 3'b111, 3'b101, 3'b100, 3'b010, 3'b001};
        fib_bit = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        gal_bit = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        load3 = 1'b1; seed3 = 3'b001; en3 = 1'b0;
        tick();
        checks++;
        if ({f_state, f_cnt, g_state, g_cnt} !== 12'b001_000_001_000) begin
            errors++; $display("FAIL small_load: got fib=%b/%0d gal=%b/%0d expected 001/0", f_state, f_cnt, g_state, g_cnt);
        end
        load3 = 1'b0; en3 = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            logic       exp_wrap;
            logic [2:0] exp_cnt;
            tick();
            exp_wrap = (k == 7) ? 1'b1 : 1'b0;
            exp_cnt  = (k == 7) ? 3'd0 : 3'(k);
            checks++;
            if (f_state !== fib_exp[k-1] || f_bit !== fib_bit[k-1]) begin
                errors++; $display("FAIL fib3_step%0d: got state=%b bit=%b expected %b %b", k, f_state, f_bit, fib_exp[k-1], fib_bit[k-1]);
            end
            checks++;
            if (f_wrap !== exp_wrap || f_cnt !== exp_cnt) begin
                errors++; $display("FAIL fib3_wrapcnt%0d: got wrap=%b cnt=%0d expected %b %0d", k, f_wrap, f_cnt, exp_wrap, exp_cnt);
            end
            checks++;
            if (g_state !== gal_exp[k-1] || g_bit !== gal_bit[k-1]) begin
                errors++; $display("FAIL gal3_step%0d: got state=%b bit=%b expected %b %b", k, g_state, g_bit, gal_exp[k-1], gal_bit[k-1]);
            end
            checks++;
            if (g_wrap !== exp_wrap || g_cnt !== exp_cnt) begin
                errors++; $display("FAIL gal3_wrapcnt%0d: got wrap=%b cnt=%0d expected %b %0d", k, g_wrap, g_cnt, exp_wrap, exp_cnt);
            end
        end
        en3 = 1'b0;
    endtask

    task automatic test_full_period();
        int wraps;
        int wrap_at;
        int zero_seen;
        logic [15:0] max_cnt;
        wraps = 0; wrap_at = 0; zero_seen = 0; max_cnt = 16'h0000;
        en = 1'b1;
        for (int k = 1; k <= 65535; k++) begin
            tick();
            if (wrap === 1'b1) begin
                wraps++;
                wrap_at = k;
            end
            if (state === 16'h0000) zero_seen++;
            if (step_cnt > max_cnt) max_cnt = step_cnt;
            if (k == 1) begin
                checks++;
                if (state !== 16'hB400 || bit_out !== 1'b1) begin
                    errors++; $display("FAIL gal16_step1: got %h bit=%b expected b400 1", state, bit_out);
                end
            end
            if (k == 2) begin
                checks++;
                if (state !== 16'h5A00 || bit_out !== 1'b0) begin
                    errors++; $display("FAIL gal16_step2: got %h bit=%b expected 5a00 0", state, bit_out);
                end
            end
        end
        en = 1'b0;
        checks++;
        if (wraps != 1 || wrap_at != 65535) begin
            errors++; $display("FAIL period_wrap: got %0d wraps, last at %0d expected 1 at 65535", wraps, wrap_at);
        end
        checks++;
        if (zero_seen != 0) begin
            errors++; $display("FAIL period_zero: got %0d zero states expected 0", zero_seen);
        end
        checks++;
        if (max_cnt !== 16'd65534) begin
            errors++; $display("FAIL period_maxcnt: got %0d expected 65534", max_cnt);
        end
        checks++;
        if (state !== 16'h0001 || step_cnt !== 16'h0000) begin
            errors++; $display("FAIL period_end: got %h cnt=%0d expected 0001 0", state, step_cnt);
        end
    endtask

    task automatic test_zero_seed();
        en = 1'b1;
        tick();
        checks++;
        if (state !== 16'hB400 || step_cnt !== 16'd1 || bit_out !== 1'b1) begin
            errors++; $display("FAIL zs_prestep: got %h cnt=%0d bit=%b expected b400 1 1", state, step_cnt, bit_out);
        end
        load = 1'b1; seed = 16'h0000;
        tick();
        checks++;
        if (state !== 16'h0001 || lockup_err !== 1'b1 || step_cnt !== 16'd0) begin
            errors++; $display("FAIL zero_seed: got %h lock=%b cnt=%0d expected 0001 1 0", state, lockup_err, step_cnt);
        end
        checks++;
        if (bit_out !== 1'b1 || wrap !== 1'b0) begin
            errors++; $display("FAIL zero_seed_hold: got bit=%b wrap=%b expected 1 0", bit_out, wrap);
        end
        seed = 16'hACE1;
        tick();
        checks++;
        if (state !== 16'hACE1 || lockup_err !== 1'b0) begin
            errors++; $display("FAIL reload_clear: got %h lock=%b expected ace1 0", state, lockup_err);
        end
        load = 1'b0;
        tick();
        checks++;
        if (state !== 16'hE270 || bit_out !== 1'b1 || step_cnt !== 16'd1) begin
            errors++; $display("FAIL ace1_step: got %h bit=%b cnt=%0d expected e270 1 1", state, bit_out, step_cnt);
        end
    endtask

    task automatic test_load_priority();
        load = 1'b1; en = 1'b1; seed = 16'h1234;
        tick();
        checks++;
        if (state !== 16'h1234 || wrap !== 1'b0 || step_cnt !== 16'd0 || bit_out !== 1'b1) begin
            errors++; $display("FAIL load_prio: got %h wrap=%b cnt=%0d bit=%b expected 1234 0 0 1", state, wrap, step_cnt, bit_out);
        end
        load = 1'b0; en = 1'b0; seed = 16'h0000;
        for (int k = 1; k <= 5; k++) begin
            tick();
            checks++;
            if (state !== 16'h1234 || bit_out !== 1'b1 || wrap !== 1'b0 || lockup_err !== 1'b0 || step_cnt !== 16'd0) begin
                errors++; $display("FAIL hold%0d: got %h bit=%b wrap=%b lock=%b cnt=%0d expected 1234 1 0 0 0", k, state, bit_out, wrap, lockup_err, step_cnt);
            end
        end
    endtask

    task automatic test_async_reset();
        en = 1'b1;
        for (int k = 1; k <= 100; k++) tick();
        checks++;
        if (step_cnt !== 16'd100) begin
            errors++; $display("FAIL pre_reset_cnt: got %0d expected 100", step_cnt);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (state !== 16'h0001 || step_cnt !== 16'd0 || {bit_out, wrap, lockup_err} !== 3'b000) begin
            errors++; $display("FAIL async_reset: got %h cnt=%0d flags=%b expected 0001 0 000", state, step_cnt, {bit_out, wrap, lockup_err});
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        checks++;
        if (state !== 16'hB400) begin
            errors++; $display("FAIL restart1: got %h expected b400", state);
        end
        tick();
        checks++;
        if (state !== 16'h5A00 || step_cnt !== 16'd2) begin
            errors++; $display("FAIL restart2: got %h cnt=%0d expected 5a00 2", state, step_cnt);
        end
        en = 1'b0;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst_n  = 1'b0;
        en     = 1'b0;
        load   = 1'b0;
        seed   = 16'h0000;
        en3    = 1'b0;
        load3  = 1'b0;
        seed3  = 3'b000;
        #12;
        test_reset();
        rst_n = 1'b1;
        test_small_widths();
        test_full_period();
        test_zero_seed();
        test_load_priority();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_lfsr_prbs_gen

// File: doc/lfsr_prbs_gen.md
Name: lfsr_prbs_gen

Overview:
- Parametrised LFSR / PRBS generator: configurable width, tap mask and topology (Fibonacci or Galois).
- Adds seed load, step enable, all-zero lockup protection, a period-wrap strobe and a step counter.
- Serves as the shared pseudo-random source for scramblers, BIST pattern generation and testbench stimulus inside the sequential_circuits library.

Parameters:
- WIDTH, 16, state register width (>= 3).
- MODE, LFSR_GAL, topology; lfsr_pkg::LFSR_FIB or lfsr_pkg::LFSR_GAL.
- TAPS, 16'hB400, WIDTH-bit feedback mask. Maximal 16-bit values: Galois 16'hB400, Fibonacci 16'h002D.
- RESET_SEED, 16'h0001, state after reset and after lockup recovery; must be nonzero.
- CNT_W, WIDTH, step counter width.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  advance one step this cycle.
- load  in  1  load seed this cycle; has priority over en.
- seed  in  WIDTH  seed value, sampled when load=1.
- state  out  WIDTH  current LFSR state (registered).
- bit_out  out  1  bit shifted out by the most recent step (registered).
- wrap  out  1  one-cycle pulse: the step just taken returned state to the active seed.
- lockup_err  out  1  sticky flag: a zero seed was loaded.
- step_cnt  out  CNT_W  steps taken since the last reset, load or wrap.

Behaviour:
- Reset (rst_n=0, asynchronous, takes effect immediately, including mid-sequence):
  - state=RESET_SEED, seed_reg=RESET_SEED.
  - bit_out=0, wrap=0, lockup_err=0, step_cnt=0.
- One step, with s = state:
  - Fibonacci: fb = ^(s & TAPS); next = {fb, s[WIDTH-1:1]}; bit_out <= s[0].
  - Galois: next = (s >> 1) ^ ({WIDTH{s[0]}} & TAPS); bit_out <= s[0].
- Per-cycle priority on the clock edge:
  - load=1, seed!=0: state<=seed, seed_reg<=seed, step_cnt<=0, lockup_err<=0, wrap<=0, bit_out holds. en is ignored.
  - load=1, seed==0: state<=RESET_SEED, seed_reg<=RESET_SEED, step_cnt<=0, lockup_err<=1, wrap<=0.
  - load=0, en=1: state<=next, bit_out<=s[0].
    - If next==seed_reg: wrap<=1, step_cnt<=0.
    - Otherwise: wrap<=0, step_cnt<=step_cnt+1 (modulo 2^CNT_W).
  - load=0, en=0: all registers hold; wrap<=0.
- Latency:
  - state, bit_out and wrap are valid the cycle after the enabling edge.
  - Step k after a load (k>=1) is visible k cycles later with continuous en.
- State can never be zero:
  - A legal TAPS gives a permutation of the state space, and zero seeds are intercepted.
  - As defensive recovery, if state==0 is ever observed with load=0, the next edge forces state<=RESET_SEED and lockup_err<=1.
- Full period: with a maximal TAPS, wrap pulses every 2^WIDTH-1 enabled steps, and step_cnt peaks at 2^WIDTH-2.
- Elaboration checks (fatal):
  - RESET_SEED==0.
  - Fibonacci with TAPS[0]==0.
  - Galois with TAPS[WIDTH-1]==0.
  - CNT_W<1.
- No combinational path from inputs to outputs.

Decomposition:
- lfsr_pkg holds:
  - typedef enum lfsr_mode_e {LFSR_FIB, LFSR_GAL}.
  - Maximal tap constants for widths 3..32, in both Fibonacci and Galois form.
  - A localparam helper function that validates TAPS against MODE.
- One combinational sub-module, lfsr_next_state, parameterised by WIDTH/MODE/TAPS: maps s to {next, out_bit}.
- Top-level register, priority, wrap, counter and lockup logic live in lfsr_prbs_gen.

Test Plan:
- WIDTH=3, FIB, TAPS=3'b011; load seed 3'b001, then en=1 for 7 cycles:
  - state sequence 100,010,101,110,111,011,001.
  - wrap=1 only on the 7th step; step_cnt runs 1..6 then 0.
- WIDTH=3, GAL, TAPS=3'b110; load 3'b001, then 7 steps:
  - state sequence 110,011,111,101,100,010,001.
  - bit_out sequence 1,0,1,1,1,0,0; wrap on step 7.
- Default 16-bit GAL; from reset, run 65535 steps:
  - exactly one wrap pulse, at step 65535.
  - state never 0; max step_cnt=65534.
- load=1 with seed=0 while en=1:
  - next cycle state=16'h0001, lockup_err=1, step_cnt=0.
  - A subsequent load of 16'hACE1 clears lockup_err.
- load=1 and en=1 in the same cycle with seed=16'h1234: state=16'h1234, no step, wrap=0.
  - Then hold en=0 for 5 cycles: all outputs stable.
- Assert rst_n=0 asynchronously mid-run (between edges, after 100 steps):
  - outputs go to reset values immediately, without a clock edge.
  - After release, the sequence restarts from RESET_SEED.
